// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Definitions shared by the UART transmitter and receiver:
//   state_t       - FSM state encoding (IDLE/START/DATA/STOP/PARITY)
//   clks_per_bit  - system clocks per serial bit for a given clock and baud
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    PARITY = 3'd4
  } state_t;

  // Integer division truncates; the residual baud error is tolerated
  // because every bit is sampled at its centre.
  function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// ----------------------------------------------------------------------------
// sync_2ff
// Generic two-flop synchroniser for a single asynchronous input.
// Parameters:
//   RST_VAL - value both flops take during reset (1 suits idle-high lines)
// Ports:
//   clk_i - destination clock
//   rst_i - asynchronous active-high reset
//   d_i   - asynchronous input
//   q_o   - synchronised output (two clocks of latency)
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/receiver.sv
// ----------------------------------------------------------------------------
// receiver
// UART receive path: deserialises 8N1 frames from the rx line, checks start
// and stop bits and presents each good byte with a one-cycle valid strobe.
// Build option:
//   UART_RX_PARITY_EN - adds an even-parity bit between data and stop;
//                       otherwise the frame is 8N1 and parity_err is 0.
// Parameters:
//   CLK_FREQ  - system clock in Hz
//   BAUD_RATE - serial bit rate
// Ports:
//   clk        - system clock
//   rst        - asynchronous active-high reset
//   rx         - asynchronous serial input, idles high
//   data_out   - last correctly framed byte
//   data_valid - one-cycle pulse, data_out is new
//   frame_err  - one-cycle pulse, stop bit sampled low
//   parity_err - one-cycle pulse on parity mismatch
//   rx_busy    - high while a frame is in progress
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module receiver
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 24_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       rx_busy
);

  localparam int CYC_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int HALF_BIT    = CYC_PER_BIT / 2;

  localparam logic [15:0] BIT_END  = 16'(CYC_PER_BIT - 1);
  localparam logic [15:0] HALF_END = 16'(HALF_BIT - 1);

  logic        rx_s;
  logic        rx_s_d_q;
  state_t      state_q;
  logic [15:0] clk_count_q;
  logic [2:0]  bit_index_q;
  logic [7:0]  shift_q;
  logic [7:0]  data_q;
  logic        data_valid_q;
  logic        frame_err_q;
  logic        rx_busy_q;
`ifdef UART_RX_PARITY_EN
  logic        parity_q;
  logic        parity_err_q;
`endif

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk_i (clk),
    .rst_i (rst),
    .d_i   (rx),
    .q_o   (rx_s)
  );

  // Delayed copy of the synchronised line for start-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_s_d_q <= 1'b1;
    else     rx_s_d_q <= rx_s;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      clk_count_q  <= '0;
      bit_index_q  <= '0;
      shift_q      <= '0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      rx_busy_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_q     <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      clk_count_q  <= clk_count_q + 16'd1;

      case (state_q)
        IDLE: begin
          clk_count_q <= '0;
          // Only a genuine high-to-low transition starts a frame, so a line
          // stuck low (break) never produces a stream of bogus bytes.
          if (rx_s_d_q && !rx_s) begin
            state_q   <= START;
            rx_busy_q <= 1'b1;
          end
        end

        START: begin
          if (clk_count_q == HALF_END) begin
            clk_count_q <= '0;
            if (!rx_s) begin
              state_q     <= DATA;
              bit_index_q <= '0;
            end else begin
              // Line back high at mid-start: treat as a glitch.
              state_q   <= IDLE;
              rx_busy_q <= 1'b0;
            end
          end
        end

        DATA: begin
          if (clk_count_q == BIT_END) begin
            clk_count_q <= '0;
            shift_q     <= {rx_s, shift_q[7:1]};
            bit_index_q <= bit_index_q + 3'd1;
            if (bit_index_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_q <= PARITY;
`else
              state_q <= STOP;
`endif
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (clk_count_q == BIT_END) begin
            clk_count_q <= '0;
            parity_q    <= rx_s;
            state_q     <= STOP;
          end
        end
`endif

        STOP: begin
          // Leaving at mid-stop lets the next start edge be caught even
          // when it follows the stop bit with no idle gap.
          if (clk_count_q == BIT_END) begin
            clk_count_q <= '0;
            state_q     <= IDLE;
            rx_busy_q   <= 1'b0;
            if (rx_s) begin
`ifdef UART_RX_PARITY_EN
              if (^{shift_q, parity_q}) begin
                parity_err_q <= 1'b1;
              end else begin
                data_q       <= shift_q;
                data_valid_q <= 1'b1;
              end
`else
              data_q       <= shift_q;
              data_valid_q <= 1'b1;
`endif
            end else begin
              frame_err_q <= 1'b1;
            end
          end
        end

        default: begin
          state_q     <= IDLE;
          clk_count_q <= '0;
          rx_busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign data_out   = data_q;
  assign data_valid = data_valid_q;
  assign frame_err  = frame_err_q;
  assign rx_busy    = rx_busy_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_receiver.sv
// ----------------------------------------------------------------------------
// tb_receiver
// Directed bench for the UART receiver at default parameters
// (CYC_PER_BIT = 208, HALF_BIT = 104). Honours UART_RX_PARITY_EN.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_receiver;

  localparam int CYC  = 208;
  localparam int HALF = 104;
`ifdef UART_RX_PARITY_EN
  localparam int FBITS = 11;
  logic par_bad = 1'b0;
`else
  localparam int FBITS = 10;
`endif
  // rx fall -> data_valid visible: 2 sync + HALF + (FBITS-1) bits + 1 register
  localparam int LATENCY = 2 + HALF + (FBITS - 1) * CYC + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       parity_err;
  logic       rx_busy;

  receiver dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .rx_busy    (rx_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor: counts every high cycle of each strobe.
  int         vcnt = 0;
  int         fcnt = 0;
  int         pcnt = 0;
  int         both = 0;
  logic [7:0] vdat [0:31];
  int         vtim [0:31];

  always @(negedge clk) begin
    if (data_valid) begin
      if (vcnt < 32) begin
        vdat[vcnt] = data_out;
        vtim[vcnt] = cyc;
      end
      vcnt = vcnt + 1;
    end
    if (frame_err)  fcnt = fcnt + 1;
    if (parity_err) pcnt = pcnt + 1;
    if (data_valid && frame_err) both = both + 1;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (CYC) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^d) ^ par_bad);
`endif
    send_bit(stop_b);
  endtask

  int t0, v0, f0;

  initial begin
    // Reset state
    rst = 1'b1;
    rx  = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_data_out",   32'(data_out),   32'h00);
    check("rst_data_valid", 32'(data_valid), 32'h0);
    check("rst_frame_err",  32'(frame_err),  32'h0);
    check("rst_parity_err", 32'(parity_err), 32'h0);
    check("rst_rx_busy",    32'(rx_busy),    32'h0);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // Clean frame 0xA5
    t0 = cyc;
    send_frame(8'hA5, 1'b1);
    repeat (10) @(negedge clk);
    check("a5_vcnt",     32'(vcnt),         32'd1);
    check("a5_vdat",     32'(vdat[0]),      32'hA5);
    check("a5_data_out", 32'(data_out),     32'hA5);
    check("a5_latency",  32'(vtim[0] - t0), 32'(LATENCY));
    check("a5_fcnt",     32'(fcnt),         32'd0);
    check("a5_busy",     32'(rx_busy),      32'h0);

    // Short low glitch rejected at mid-start
    v0 = vcnt; f0 = fcnt;
    rx = 1'b0;
    repeat (20) @(negedge clk);
    check("glitch_busy_hi", 32'(rx_busy), 32'h1);
    repeat (30) @(negedge clk);
    rx = 1'b1;
    repeat (300) @(negedge clk);
    check("glitch_busy_lo", 32'(rx_busy), 32'h0);
    check("glitch_vcnt",    32'(vcnt),    32'(v0));
    check("glitch_fcnt",    32'(fcnt),    32'(f0));

    // 0x3C with bad stop bit, then line held low
    send_frame(8'h3C, 1'b0);
    repeat (3000) @(negedge clk);
    check("ferr_fcnt",     32'(fcnt),     32'(f0 + 1));
    check("ferr_vcnt",     32'(vcnt),     32'(v0));
    check("ferr_data_out", 32'(data_out), 32'hA5);
    check("ferr_busy",     32'(rx_busy),  32'h0);
    rx = 1'b1;
    repeat (500) @(negedge clk);
    check("brk_fcnt", 32'(fcnt), 32'(f0 + 1));
    check("brk_vcnt", 32'(vcnt), 32'(v0));

    // Back-to-back 0x00 then 0xFF, no idle gap
    v0 = vcnt;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    repeat (20) @(negedge clk);
    check("b2b_vcnt",     32'(vcnt),                    32'(v0 + 2));
    check("b2b_first",    32'(vdat[v0]),                32'h00);
    check("b2b_second",   32'(vdat[v0 + 1]),            32'hFF);
    check("b2b_spacing",  32'(vtim[v0 + 1] - vtim[v0]), 32'(FBITS * CYC));
    check("b2b_data_out", 32'(data_out),                32'hFF);

    // Reset during data bit 4 of 0x5A, then a clean 0x5A
    v0 = vcnt; f0 = fcnt;
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    repeat (100) @(negedge clk);
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    check("mrst_data_out",   32'(data_out),   32'h00);
    check("mrst_busy",       32'(rx_busy),    32'h0);
    check("mrst_data_valid", 32'(data_valid), 32'h0);
    check("mrst_frame_err",  32'(frame_err),  32'h0);
    rst = 1'b0;
    repeat (500) @(negedge clk);
    check("mrst_no_vpulse", 32'(vcnt), 32'(v0));
    check("mrst_no_fpulse", 32'(fcnt), 32'(f0));
    send_frame(8'h5A, 1'b1);
    repeat (20) @(negedge clk);
    check("post_rst_vcnt", 32'(vcnt),     32'(v0 + 1));
    check("post_rst_data", 32'(data_out), 32'h5A);

`ifdef UART_RX_PARITY_EN
    // 0x07 has three ones: even parity bit must be 1
    v0 = vcnt;
    par_bad = 1'b1;
    send_frame(8'h07, 1'b1);
    repeat (20) @(negedge clk);
    check("par_bad_pcnt", 32'(pcnt),     32'd1);
    check("par_bad_vcnt", 32'(vcnt),     32'(v0));
    check("par_bad_data", 32'(data_out), 32'h5A);
    par_bad = 1'b0;
    send_frame(8'h07, 1'b1);
    repeat (20) @(negedge clk);
    check("par_ok_vcnt", 32'(vcnt),     32'(v0 + 1));
    check("par_ok_data", 32'(data_out), 32'h07);
    check("par_ok_pcnt", 32'(pcnt),     32'd1);
`else
    check("no_parity_pulses", 32'(pcnt), 32'd0);
`endif

    check("valid_ferr_exclusive", 32'(both), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
